mips_timer_io: RTL and testbench

- Memory-mapped timer peripheral on the CPU data port, directly downstream of the MEM stage.
- Consumes the CPU's memaddr, memwrite and memwritedata, and returns read data combinationally in the same cycle.
- The system-level read mux selects this read data when `hit` is asserted.
- Provides a prescaled 32-bit down-counter with auto-reload, an expiry flag and a level interrupt.

---
 rtl/mips_timer_io.sv | 176 +++++++++++++++++
 tb/tb_mips_timer_io.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_timer_io.sv
// Memory-mapped prescaled down-counter timer on the CPU data port.
// Combinational decode and read-back; all timer state lives in flops, irq included.
module mips_timer_io #(
    parameter logic [31:0] BASE       = 32'hFFFF0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic [31:0] memwritedata,
    output logic        hit,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_LOAD     = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    logic [2:0]            r_ctrl;
    logic [31:0]           r_load;
    logic [31:0]           r_count;
    logic                  r_expired;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_irq;

    logic                  w_hit;
    logic [2:0]            w_off;
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_load;
    logic                  w_wr_count;
    logic                  w_wr_status;
    logic                  w_wr_prescale;
    logic                  w_tick;
    logic                  w_expire;
    logic                  w_unused_addr;

    logic [2:0]            w_ctrl_next;
    logic [31:0]           w_load_next;
    logic [31:0]           w_count_next;
    logic                  w_expired_next;
    logic [PRESCALE_W-1:0] w_prescale_next;
    logic [PRESCALE_W-1:0] w_pcnt_next;
    logic                  w_irq_next;

    // Address decode and per-register write strobes; byte-lane bits are don't-care.
    always_comb begin
        w_hit         = (memaddr[31:5] == BASE[31:5]);
        w_off         = memaddr[4:2];
        w_wr          = memwrite & w_hit;
        w_wr_ctrl     = w_wr & (w_off == OFF_CTRL);
        w_wr_load     = w_wr & (w_off == OFF_LOAD);
        w_wr_count    = w_wr & (w_off == OFF_COUNT);
        w_wr_status   = w_wr & (w_off == OFF_STATUS);
        w_wr_prescale = w_wr & (w_off == OFF_PRESCALE);
        w_unused_addr = ^memaddr[1:0];
    end

    // Prescaler compare and terminal-count detection.
    always_comb begin
        w_tick   = r_ctrl[0] & (r_pcnt == r_prescale);
        w_expire = w_tick & (r_count == 32'd0);
    end

    // Next-state for all registers; CPU writes take priority over timer updates
    // except that an expiry beats a same-cycle W1C of EXPIRED.
    always_comb begin
        w_ctrl_next     = r_ctrl;
        w_load_next     = r_load;
        w_count_next    = r_count;
        w_expired_next  = r_expired;
        w_prescale_next = r_prescale;
        w_pcnt_next     = r_pcnt;
        w_irq_next      = 1'b0;

        if (w_wr_ctrl) begin
            w_ctrl_next = memwritedata[2:0];
        end else if (w_expire && !r_ctrl[1]) begin
            w_ctrl_next = {r_ctrl[2:1], 1'b0};
        end else begin
            w_ctrl_next = r_ctrl;
        end

        if (w_wr_load) begin
            w_load_next = memwritedata;
        end else begin
            w_load_next = r_load;
        end

        if (w_wr_count) begin
            w_count_next = memwritedata;
        end else if (w_tick) begin
            if (r_count != 32'd0) begin
                w_count_next = r_count - 32'd1;
            end else if (r_ctrl[1]) begin
                w_count_next = r_load;
            end else begin
                w_count_next = 32'd0;
            end
        end else begin
            w_count_next = r_count;
        end

        if (w_expire) begin
            w_expired_next = 1'b1;
        end else if (w_wr_status && memwritedata[0]) begin
            w_expired_next = 1'b0;
        end else begin
            w_expired_next = r_expired;
        end

        if (w_wr_prescale) begin
            w_prescale_next = memwritedata[PRESCALE_W-1:0];
        end else begin
            w_prescale_next = r_prescale;
        end

        // A tick or a shrunken PRESCALE (pcnt past the compare) both restart at 0.
        if (!r_ctrl[0] || !w_ctrl_next[0]) begin
            w_pcnt_next = '0;
        end else if (r_pcnt >= r_prescale) begin
            w_pcnt_next = '0;
        end else begin
            w_pcnt_next = r_pcnt + PRESCALE_W'(1);
        end

        w_irq_next = w_expired_next & w_ctrl_next[2];
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl     <= 3'd0;
            r_load     <= 32'd0;
            r_count    <= 32'd0;
            r_expired  <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_next;
            r_load     <= w_load_next;
            r_count    <= w_count_next;
            r_expired  <= w_expired_next;
            r_prescale <= w_prescale_next;
            r_pcnt     <= w_pcnt_next;
            r_irq      <= w_irq_next;
        end
    end

    // Combinational read mux; the system mux only looks at it when hit is high.
    always_comb begin
        readdata = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_CTRL:     readdata = {29'd0, r_ctrl};
                OFF_LOAD:     readdata = r_load;
                OFF_COUNT:    readdata = r_count;
                OFF_STATUS:   readdata = {31'd0, r_expired};
                OFF_PRESCALE: readdata = 32'(r_prescale);
                default:      readdata = 32'd0;
            endcase
        end else begin
            readdata = 32'd0;
        end
    end

    assign hit = w_hit;
    assign irq = r_irq;

endmodule

// File: tb/tb_mips_timer_io.sv
// Randomised bench for mips_timer_io against a cycle-level register model.
module tb_mips_timer_io;

    localparam logic [31:0] BASE = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memaddr;
    logic        memwrite;
    logic [31:0] memwritedata;
    logic        hit;
    logic [31:0] readdata;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_rd;
    logic        last_irq;
    logic        last_hit;

    // reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_load;
    logic [31:0] m_count;
    logic        m_exp;
    logic [15:0] m_pre;
    logic [15:0] m_pcnt;
    logic        m_irq;

    mips_timer_io #(.BASE(BASE), .PRESCALE_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .memaddr      (memaddr),
        .memwrite     (memwrite),
        .memwritedata (memwritedata),
        .hit          (hit),
        .readdata     (readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a & 32'hFFFF_FFE0) == BASE;
    endfunction

    function automatic logic [31:0] addr_of(input int off);
        return BASE + 32'(off * 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!in_win(a)) return 32'd0;
        case (a[4:2])
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {31'd0, m_exp};
            3'd4:    return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_clear();
        m_ctrl = 3'd0; m_load = 32'd0; m_count = 32'd0;
        m_exp = 1'b0; m_pre = 16'd0; m_pcnt = 16'd0; m_irq = 1'b0;
    endtask

    // One clock edge of the timer described as register-map rules.
    task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          wr     = we && in_win(a);
        logic [2:0]  off    = a[4:2];
        bit          en     = m_ctrl[0];
        bit          tick   = en && (m_pcnt == m_pre);
        bit          expire = tick && (m_count == 32'd0);
        logic [2:0]  nctrl  = m_ctrl;
        logic [31:0] nload  = m_load;
        logic [31:0] ncount = m_count;
        logic        nexp   = m_exp;
        logic [15:0] npre   = m_pre;
        logic [15:0] npcnt;
        if (tick) begin
            if (m_count == 32'd0) begin
                nexp = 1'b1;
                if (m_ctrl[1]) ncount = m_load;
                else           nctrl[0] = 1'b0;
            end else begin
                ncount = m_count - 32'd1;
            end
        end
        if (wr) begin
            case (off)
                3'd0: nctrl  = d[2:0];
                3'd1: nload  = d;
                3'd2: ncount = d;
                3'd3: if (d[0] && !expire) nexp = 1'b0;
                3'd4: npre   = d[15:0];
                default: ;
            endcase
        end
        if (!en || !nctrl[0] || m_pcnt >= m_pre) npcnt = 16'd0;
        else                                     npcnt = m_pcnt + 16'd1;
        m_ctrl = nctrl; m_load = nload; m_count = ncount;
        m_exp = nexp; m_pre = npre; m_pcnt = npcnt;
        m_irq = nexp && nctrl[2];
    endtask

    task automatic do_cycle(input bit we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memaddr = a; memwrite = we; memwritedata = d;
        #1;
        last_rd = readdata; last_irq = irq; last_hit = hit;
        chk("hit", 32'(hit), 32'(in_win(a)));
        chk("rdata", readdata, m_read(a));
        chk("irq", 32'(irq), 32'(m_irq));
        @(posedge clk);
        cyc++;
        if (reset) model_step(we, a, d);
        else       model_clear();
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        do_cycle(1'b1, addr_of(off), d);
    endtask

    task automatic rd(input int off);
        do_cycle(1'b0, addr_of(off), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        memwrite = 1'b0;
        #2 reset = 1'b0;
        #1 chk("rst_irq_async", 32'(irq), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 5; r++) begin
            rd(r);
            chk("rst_reg_zero", last_rd, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        reset = 1'b0; memaddr = BASE; memwrite = 1'b0; memwritedata = 32'd0;
        model_clear();
        #1 chk("init_irq", 32'(irq), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 5; r++) begin
            rd(r);
            chk("init_reg_zero", last_rd, 32'd0);
        end

        // one-shot, PRESCALE=0
        wr(4, 32'd0); wr(2, 32'd3); wr(0, 32'd5);
        rd(2);
        rd(2); chk("os_cnt2", last_rd, 32'd2);
        rd(2); chk("os_cnt1", last_rd, 32'd1);
        rd(2); chk("os_cnt0", last_rd, 32'd0);
        rd(3); chk("os_expired", last_rd, 32'd1); chk("os_irq", 32'(last_irq), 32'd1);
        rd(0); chk("os_ctrl", last_rd, 32'd4);
        rd(2); chk("os_hold0", last_rd, 32'd0);
        wr(3, 32'd1);

        // auto-reload, period (4+1)*(2+1)
        wr(1, 32'd4); wr(2, 32'd4); wr(4, 32'd2); wr(0, 32'd7);
        t1 = -1;
        for (int i = 0; i < 40 && t1 < 0; i++) begin
            rd(3);
            if (last_rd == 32'd1) t1 = cyc;
        end
        if (t1 < 0) chk("ar_timeout1", 32'd0, 32'd1);
        wr(3, 32'd1);
        rd(3); chk("ar_w1c_irq", 32'(last_irq), 32'd0);
        t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            rd(3);
            if (last_rd == 32'd1) t2 = cyc;
        end
        if (t2 < 0) chk("ar_timeout2", 32'd0, 32'd1);
        chk("ar_period", 32'(t2 - t1), 32'd15);
        chk("ar_irq_again", 32'(last_irq), 32'd1);

        // COUNT write on a tick cycle
        for (int i = 0; i < 10 && !(m_ctrl[0] && m_pcnt == m_pre); i++) rd(2);
        wr(2, 32'd100);
        rd(2); chk("col_count", last_rd, 32'd100);

        // W1C coinciding with expiry
        wr(3, 32'd1); wr(2, 32'd0);
        for (int i = 0; i < 10 && !(m_ctrl[0] && m_pcnt == m_pre && m_count == 32'd0); i++) rd(2);
        wr(3, 32'd1);
        rd(3); chk("col_w1c", last_rd, 32'd1);

        // reset mid-count
        wr(2, 32'd5);
        do_reset();

        // decode
        wr(5, 32'hFFFF);
        rd(5); chk("dec_14_rd", last_rd, 32'd0); chk("dec_14_hit", 32'(last_hit), 32'd1);
        do_cycle(1'b1, BASE + 32'h1C, 32'd7);
        chk("dec_1c_hit", 32'(last_hit), 32'd1); chk("dec_1c_rd", last_rd, 32'd0);
        do_cycle(1'b1, BASE + 32'h20, 32'd7);
        chk("dec_20_hit", 32'(last_hit), 32'd0); chk("dec_20_rd", last_rd, 32'd0);
        rd(0); chk("dec_20_nowr", last_rd, 32'd0);

        // byte offset within LOAD word
        do_cycle(1'b1, BASE + 32'h6, 32'h1234);
        rd(1); chk("byte_load", last_rd, 32'h1234);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            int          pick;
            int          off;
            logic [31:0] a;
            logic [31:0] d;
            bit          we;
            pick = $urandom_range(0, 199);
            if (pick == 0) begin
                do_reset();
            end else begin
                off = $urandom_range(0, 7);
                if (pick < 180) a = addr_of(off) | 32'($urandom_range(0, 3));
                else if (pick < 190) a = BASE + 32'h20 + 32'(off * 4);
                else a = $urandom;
                we = ($urandom_range(0, 2) == 0);
                case (a[4:2])
                    3'd1:    d = 32'($urandom_range(0, 6));
                    3'd2:    d = 32'($urandom_range(0, 8));
                    3'd4:    d = 32'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                do_cycle(we, a, d);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
